// File: rtl/bh1750_i2c_target_if.sv
// Raw I2C pin bundle between a bus master and the BH1750 target model.
// SDA is open-drain: the target only ever asserts sda_oe to pull the line low.
interface bh1750_i2c_target_if;
  logic scl;
  logic sda_in;
  logic sda_oe;

  modport slave  (input scl, input sda_in, output sda_oe);
  modport master (output scl, output sda_in, input sda_oe);
endinterface

// File: rtl/bh1750_i2c_target.sv
// I2C target answering as a BH1750 light sensor: latches written command bytes and
// returns a programmable 16-bit lux value (then 8'hFF padding) on reads.
module bh1750_i2c_target #(
  parameter logic [6:0] DEV_ADDR = 7'h23
) (
  input  logic                       clk,
  input  logic                       rst,
  bh1750_i2c_target_if.slave         bus,
  input  logic [15:0]                lux_data,
  output logic [7:0]                 cmd,
  output logic                       cmd_valid,
  output logic                       busy
);

  typedef enum logic [2:0] {
    StIdle, StAddr, StAddrAck, StWrByte, StWrAck, StRdByte, StRdAck, StWaitStop
  } state_e;

  state_e      state_q, state_d;
  logic        scl_m, scl_s, scl_d, sda_m, sda_s, sda_d;
  logic [2:0]  bit_cnt_q, bit_cnt_d;
  logic [7:0]  shift_q, shift_d;
  logic        rw_q, rw_d;
  logic        done_q, done_d;
  logic [6:0]  tx_q, tx_d;
  logic [1:0]  idx_q, idx_d;
  logic [7:0]  lux_lo_q, lux_lo_d;
  logic        sda_oe_q, sda_oe_d;
  logic [7:0]  cmd_q, cmd_d;
  logic        cmd_valid_q, cmd_valid_d;
  logic [7:0]  next_byte;
  logic        rise, fall, start, stop, addr_hit;

  assign rise     = ~scl_d & scl_s;
  assign fall     = scl_d & ~scl_s;
  assign start    = scl_d & scl_s & sda_d & ~sda_s;
  assign stop     = scl_d & scl_s & ~sda_d & sda_s;
  assign addr_hit = (shift_q[7:1] == DEV_ADDR);
  // Byte after the one just acknowledged: low lux byte once, then padding.
  assign next_byte = (idx_q == 2'd0) ? lux_lo_q : 8'hFF;

  assign bus.sda_oe = sda_oe_q;
  assign cmd        = cmd_q;
  assign cmd_valid  = cmd_valid_q;
  assign busy       = (state_q != StIdle);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      {scl_m, scl_s, scl_d, sda_m, sda_s, sda_d} <= '1;
      state_q     <= StIdle;
      bit_cnt_q   <= '0;
      shift_q     <= '0;
      rw_q        <= 1'b0;
      done_q      <= 1'b0;
      tx_q        <= '0;
      idx_q       <= '0;
      lux_lo_q    <= '0;
      sda_oe_q    <= 1'b0;
      cmd_q       <= '0;
      cmd_valid_q <= 1'b0;
    end else begin
      {scl_m, scl_s, scl_d} <= {bus.scl, scl_m, scl_s};
      {sda_m, sda_s, sda_d} <= {bus.sda_in, sda_m, sda_s};
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      rw_q        <= rw_d;
      done_q      <= done_d;
      tx_q        <= tx_d;
      idx_q       <= idx_d;
      lux_lo_q    <= lux_lo_d;
      sda_oe_q    <= sda_oe_d;
      cmd_q       <= cmd_d;
      cmd_valid_q <= cmd_valid_d;
    end
  end

  always_comb begin
    state_d = state_q;
    if (start) begin
      state_d = StAddr;
    end else if (stop) begin
      state_d = StIdle;
    end else begin
      unique case (state_q)
        StIdle:     state_d = StIdle;
        StAddr:     if (fall && done_q) state_d = addr_hit ? StAddrAck : StWaitStop;
        StAddrAck:  if (fall) state_d = rw_q ? StRdByte : StWrByte;
        StWrByte:   if (fall && done_q) state_d = StWrAck;
        StWrAck:    if (fall) state_d = StWrByte;
        StRdByte:   if (fall && done_q) state_d = StRdAck;
        StRdAck: begin
          if (rise && sda_s)        state_d = StWaitStop;
          else if (fall && done_q)  state_d = StRdByte;
        end
        StWaitStop: state_d = StWaitStop;
        default:    state_d = StIdle;
      endcase
    end
  end

  always_comb begin
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    rw_d        = rw_q;
    done_d      = done_q;
    tx_d        = tx_q;
    idx_d       = idx_q;
    lux_lo_d    = lux_lo_q;
    sda_oe_d    = sda_oe_q;
    cmd_d       = cmd_q;
    cmd_valid_d = 1'b0;
    if (start || stop) begin
      sda_oe_d  = 1'b0;
      bit_cnt_d = '0;
      done_d    = 1'b0;
      if (start) idx_d = '0;
    end else begin
      unique case (state_q)
        StAddr, StWrByte: begin
          if (rise) begin
            shift_d   = {shift_q[6:0], sda_s};
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (fall && done_q) begin
            done_d = 1'b0;
            if (state_q == StAddr) begin
              rw_d     = shift_q[0];
              sda_oe_d = addr_hit;
            end else begin
              cmd_d       = shift_q;
              cmd_valid_d = 1'b1;
              sda_oe_d    = 1'b1;
            end
          end
        end
        StAddrAck: begin
          if (fall) begin
            sda_oe_d = 1'b0;
            if (rw_q) begin
              tx_d     = lux_data[14:8];
              lux_lo_d = lux_data[7:0];
              idx_d    = '0;
              sda_oe_d = ~lux_data[15];
            end
          end
        end
        StWrAck: if (fall) sda_oe_d = 1'b0;
        StRdByte: begin
          if (rise) begin
            bit_cnt_d = bit_cnt_q + 3'd1;
            if (bit_cnt_q == 3'd7) done_d = 1'b1;
          end else if (fall) begin
            if (done_q) begin
              done_d   = 1'b0;
              sda_oe_d = 1'b0;
            end else begin
              tx_d     = {tx_q[5:0], 1'b1};
              sda_oe_d = ~tx_q[6];
            end
          end
        end
        StRdAck: begin
          if (rise && !sda_s) begin
            done_d = 1'b1;
          end else if (fall && done_q) begin
            done_d   = 1'b0;
            idx_d    = (idx_q == 2'd2) ? 2'd2 : idx_q + 2'd1;
            tx_d     = next_byte[6:0];
            sda_oe_d = ~next_byte[7];
          end
        end
        default: sda_oe_d = 1'b0;
      endcase
    end
  end

endmodule
